bp_update_scheduler: RTL and testbench

- Sequences all writes into the branch-prediction tables: the local BHT, the global BHT and the tournament chooser.
- Buffers resolved-branch updates from the MEM stage in a small FIFO and derives each table's write-side inputs: write_pc, taken, control_flush and unchosen_pred.
- Issues at most one update per cycle as a single write strobe shared by all tables.
- After reset, sweeps every table index to its initial state and holds predictions disabled until the sweep finishes.

---
 rtl/bp_update_scheduler_pkg.sv | 50 +++++
 rtl/bp_update_scheduler_if.sv | 32 +++
 rtl/bp_update_scheduler_fifo.sv | 69 ++++++
 rtl/bp_update_scheduler.sv | 143 ++++++++++++++
 tb/tb_bp_update_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lc3b_types (package)                                         |
// | Description : Shared LC-3b types used by the branch-prediction update      |
// |               scheduler: word type, update record, table index type,      |
// |               scheduler state encoding and field-derivation helper.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam int BP_UPD_DEPTH = 4;
   localparam int BP_IDX_W     = 4;

   typedef logic [BP_IDX_W-1:0] lc3b_global_bht_pattern_index;

   // One resolved-branch update, already reduced to the table write-side fields
   typedef struct packed {
      lc3b_word pc;
      logic     taken;
      logic     control_flush;
      logic     unchosen_pred;
   } lc3b_bp_update;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_sched_state_e;

   // The chooser picks global when choice=1; a flush happens when the picked
   // prediction disagrees with the outcome, and the other predictor's guess is
   // carried along so the chooser can be trained.
   function automatic lc3b_bp_update bp_make_update(
      input lc3b_word pc,
      input logic     taken,
      input logic     local_pred,
      input logic     global_pred,
      input logic     choice
   );
      lc3b_bp_update u;
      u.pc            = pc;
      u.taken         = taken;
      u.control_flush = (choice ? global_pred : local_pred) != taken;
      u.unchosen_pred = choice ? local_pred : global_pred;
      return u;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_update_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_update_scheduler_if                                       |
// | Description : Resolved-branch update bus from the MEM stage into the       |
// |               prediction-table update scheduler.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface bp_update_scheduler_if;
   import lc3b_types::*;

   logic     upd_valid;
   lc3b_word upd_pc;
   logic     upd_taken;
   logic     upd_local_pred;
   logic     upd_global_pred;
   logic     upd_choice;
   logic     upd_ready;

   // MEM stage side
   modport master (
      output upd_valid, upd_pc, upd_taken, upd_local_pred, upd_global_pred, upd_choice,
      input  upd_ready
   );

   // Scheduler side
   modport slave (
      input  upd_valid, upd_pc, upd_taken, upd_local_pred, upd_global_pred, upd_choice,
      output upd_ready
   );

endinterface
`default_nettype wire

// File: rtl/bp_update_scheduler_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_update_fifo                                               |
// | Description : Synchronous FIFO of lc3b_bp_update records. Head entry is    |
// |               visible combinationally on dout. Push is refused when full   |
// |               even if a pop happens in the same cycle.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_update_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = BP_UPD_DEPTH
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          push,
   input  wire lc3b_bp_update din,
   input  wire logic          pop,
   output lc3b_bp_update      dout,
   output logic               full,
   output logic               empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   lc3b_bp_update    r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rd_ptr];

   // Storage array: written only on an accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; occupancy tracks both ends
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bp_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_update_scheduler                                          |
// | Description : Serialises resolved-branch updates into the local BHT,       |
// |               global BHT and tournament chooser. After reset it sweeps     |
// |               every table index to its init value, then drains queued      |
// |               updates one per cycle in arrival order.                      |
// |               Optional macro BP_UPD_STATS_EN adds update / mispredict /     |
// |               drop saturating counters on stat_* ports.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_update_scheduler
   import lc3b_types::*;
#(
   parameter int DEPTH = BP_UPD_DEPTH,
   parameter int IDX_W = BP_IDX_W
) (
   input  wire logic                clk,
   input  wire logic                reset,
   bp_update_scheduler_if.slave     upd,
   output logic                     write,
   output lc3b_word                 write_pc,
   output logic                     taken,
   output logic                     control_flush,
   output logic                     unchosen_pred,
   output logic                     init_busy,
   output logic                     init_write,
   output logic [IDX_W-1:0]         init_index,
   output logic                     pred_enable
`ifdef BP_UPD_STATS_EN
   ,
   output logic [15:0]              stat_updates,
   output logic [15:0]              stat_mispredicts,
   output logic [15:0]              stat_drops
`endif
);

   bp_sched_state_e  r_state;
   bp_sched_state_e  w_state_nxt;
   logic [IDX_W-1:0] r_sweep_idx;
   logic [IDX_W-1:0] w_sweep_idx_nxt;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   lc3b_bp_update    w_enq;
   lc3b_bp_update    w_head;

   // Readiness comes only from registered occupancy so MEM never sees a loop
   assign upd.upd_ready = !w_full;
   assign w_push        = upd.upd_valid && !w_full;
   assign w_enq         = bp_make_update(upd.upd_pc, upd.upd_taken, upd.upd_local_pred,
                                         upd.upd_global_pred, upd.upd_choice);

   bp_update_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (w_enq),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // State and sweep counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_INIT;
         r_sweep_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_idx <= w_sweep_idx_nxt;
      end
   end

   // Next-state: sweep one index per cycle, then drain the FIFO forever
   always_comb begin
      w_state_nxt     = r_state;
      w_sweep_idx_nxt = r_sweep_idx;
      w_pop           = 1'b0;
      init_busy       = 1'b0;
      init_write      = 1'b0;
      case (r_state)
         ST_INIT: begin
            init_busy       = 1'b1;
            init_write      = 1'b1;
            // Wraps back to 0 on the last index, so the counter rests at 0 in RUN
            w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
            if (&r_sweep_idx) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_pop = !w_empty;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   assign init_index    = r_sweep_idx;
   assign pred_enable   = !init_busy;
   assign write         = w_pop;
   assign write_pc      = w_pop ? w_head.pc            : '0;
   assign taken         = w_pop ? w_head.taken         : 1'b0;
   assign control_flush = w_pop ? w_head.control_flush : 1'b0;
   assign unchosen_pred = w_pop ? w_head.unchosen_pred : 1'b0;

`ifdef BP_UPD_STATS_EN
   logic [15:0] r_stat_updates;
   logic [15:0] r_stat_mispredicts;
   logic [15:0] r_stat_drops;

   // Saturating event counters for update traffic, mispredicts and dropped updates
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_updates     <= '0;
         r_stat_mispredicts <= '0;
         r_stat_drops       <= '0;
      end else begin
         if (write && (r_stat_updates != 16'hFFFF)) begin
            r_stat_updates <= r_stat_updates + 16'd1;
         end
         if (write && control_flush && (r_stat_mispredicts != 16'hFFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
         end
         if (upd.upd_valid && w_full && (r_stat_drops != 16'hFFFF)) begin
            r_stat_drops <= r_stat_drops + 16'd1;
         end
      end
   end

   assign stat_updates     = r_stat_updates;
   assign stat_mispredicts = r_stat_mispredicts;
   assign stat_drops       = r_stat_drops;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_update_scheduler                                       |
// | Description : Self-checking bench for bp_update_scheduler: directed        |
// |               vectors, multi-cycle sequences and random traffic against a  |
// |               queue-based reference model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bp_update_scheduler;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        write;
   logic [15:0] write_pc;
   logic        taken;
   logic        control_flush;
   logic        unchosen_pred;
   logic        init_busy;
   logic        init_write;
   logic [3:0]  init_index;
   logic        pred_enable;
`ifdef BP_UPD_STATS_EN
   logic [15:0] stat_updates;
   logic [15:0] stat_mispredicts;
   logic [15:0] stat_drops;
`endif

   always #5 clk = ~clk;

   bp_update_scheduler_if bus ();

   bp_update_scheduler #(
      .DEPTH (4),
      .IDX_W (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .upd           (bus),
      .write         (write),
      .write_pc      (write_pc),
      .taken         (taken),
      .control_flush (control_flush),
      .unchosen_pred (unchosen_pred),
      .init_busy     (init_busy),
      .init_write    (init_write),
      .init_index    (init_index),
      .pred_enable   (pred_enable)
`ifdef BP_UPD_STATS_EN
      ,
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts),
      .stat_drops       (stat_drops)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] pc;
      logic        t;
      logic        cf;
      logic        up;
   } ent_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic m_known = 1'b0;
   int   m_sweep = 0;       // cycles since reset; 16 or more means sweep done
   ent_t m_q[$];
   int   s_upd, s_mis, s_drop;

   logic        obs_write, obs_ready, obs_initw, obs_cf, obs_up;
   logic [15:0] obs_pc;
   logic [3:0]  obs_index;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic        e_busy;
      logic        e_write;
      logic [18:0] e_data;
      e_busy  = (m_sweep < 16);
      e_write = !e_busy && (m_q.size() > 0);
      e_data  = e_write ? {m_q[0].pc, m_q[0].t, m_q[0].cf, m_q[0].up} : 19'd0;
      chk("write", 32'(write), 32'(e_write));
      chk("write_data", 32'({write_pc, taken, control_flush, unchosen_pred}), 32'(e_data));
      chk("init_busy", 32'(init_busy), 32'(e_busy));
      chk("init_write", 32'(init_write), 32'(e_busy));
      chk("pred_enable", 32'(pred_enable), 32'(!e_busy));
      chk("upd_ready", 32'(bus.upd_ready), 32'(m_q.size() < 4));
      if (e_busy) chk("init_index", 32'(init_index), 32'(m_sweep));
`ifdef BP_UPD_STATS_EN
      chk("stat_updates", 32'(stat_updates), 32'(s_upd));
      chk("stat_mispredicts", 32'(stat_mispredicts), 32'(s_mis));
      chk("stat_drops", 32'(stat_drops), 32'(s_drop));
`endif
   endtask

   function automatic int sat(input int v);
      return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
   endfunction

   // One clock cycle: check current outputs, drive inputs, advance model across the edge
   task automatic cycle(input logic rst, input logic v, input logic [15:0] pc,
                        input logic t, input logic l, input logic g, input logic ch);
      logic acc, popd;
      ent_t e;
      if (m_known) check_outputs();
      obs_write = write;   obs_pc = write_pc;   obs_cf = control_flush;
      obs_up    = unchosen_pred;  obs_ready = bus.upd_ready;
      obs_initw = init_write;     obs_index = init_index;
      reset               = rst;
      bus.upd_valid       = v;
      bus.upd_pc          = pc;
      bus.upd_taken       = t;
      bus.upd_local_pred  = l;
      bus.upd_global_pred = g;
      bus.upd_choice      = ch;
      popd = (m_sweep >= 16) && (m_q.size() > 0);
      acc  = v && (m_q.size() < 4);
      e.pc = pc;
      e.t  = t;
      e.cf = ((ch ? g : l) != t);
      e.up = ch ? l : g;
      @(posedge clk);
      if (rst) begin
         m_sweep = 0;
         m_q.delete();
         s_upd = 0; s_mis = 0; s_drop = 0;
         m_known = 1'b1;
      end else begin
         if (v && !acc) s_drop = sat(s_drop);
         if (popd) begin
            s_upd = sat(s_upd);
            if (m_q[0].cf) s_mis = sat(s_mis);
            void'(m_q.pop_front());
         end
         if (acc) m_q.push_back(e);
         if (m_sweep < 16) m_sweep++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [15:0] pc, input logic t, input logic l,
                       input logic g, input logic ch);
      cycle(1'b0, 1'b1, pc, t, l, g, ch);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [15:0] pc;
      logic        t, l, g, ch;
      logic        exp_cf, exp_up;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int cnt, wcnt;
      logic [15:0] got_pcs[$];

      vecs[0] = '{pc:16'h3006, t:1, l:0, g:1, ch:1, exp_cf:0, exp_up:0};
      vecs[1] = '{pc:16'h3010, t:0, l:0, g:1, ch:1, exp_cf:1, exp_up:0};
      vecs[2] = '{pc:16'h3012, t:0, l:0, g:1, ch:0, exp_cf:0, exp_up:1};
      vecs[3] = '{pc:16'h1234, t:1, l:1, g:0, ch:0, exp_cf:0, exp_up:0};
      vecs[4] = '{pc:16'hBEEF, t:1, l:0, g:0, ch:1, exp_cf:1, exp_up:0};
      vecs[5] = '{pc:16'hFFFE, t:0, l:1, g:1, ch:0, exp_cf:1, exp_up:1};

      reset = 1'b1;
      bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
      bus.upd_local_pred = 1'b0; bus.upd_global_pred = 1'b0; bus.upd_choice = 1'b0;
      @(negedge clk);

      // Reset sweep: 16 init cycles, no table writes
      do_reset();
      cnt = 0; wcnt = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (i == 0)  chk("sweep_first_index", 32'(obs_index), 32'd0);
         if (i == 15) chk("sweep_last_index", 32'(obs_index), 32'd15);
         if (obs_initw) cnt++;
         if (obs_write) wcnt++;
      end
      chk("sweep_len", 32'(cnt), 32'd16);
      chk("sweep_writes", 32'(wcnt), 32'd0);

      // Single updates in RUN with field derivation
      foreach (vecs[i]) begin
         push(vecs[i].pc, vecs[i].t, vecs[i].l, vecs[i].g, vecs[i].ch);
         idle(1);
         chk("vec_write", 32'(obs_write), 32'd1);
         chk("vec_pc", 32'(obs_pc), 32'(vecs[i].pc));
         chk("vec_cf", 32'(obs_cf), 32'(vecs[i].exp_cf));
         chk("vec_unchosen", 32'(obs_up), 32'(vecs[i].exp_up));
      end

      // Queue during INIT: 4 accepted, 5th dropped, drained in order afterwards
      do_reset();
      for (int k = 0; k < 5; k++) begin
         push(16'h5000 + 16'(k), 1'b1, 1'b0, 1'b1, 1'b1);
         if (k == 4) chk("init_q_fifth_ready", 32'(obs_ready), 32'd0);
      end
      got_pcs.delete();
      for (int i = 0; i < 30; i++) begin
         idle(1);
         if (obs_write) got_pcs.push_back(obs_pc);
      end
      chk("init_q_write_count", 32'(got_pcs.size()), 32'd4);
      for (int k = 0; k < 4 && k < got_pcs.size(); k++)
         chk("init_q_order", 32'(got_pcs[k]), 32'h5000 + 32'(k));
`ifdef BP_UPD_STATS_EN
      chk("init_q_stat_drops", 32'(stat_drops), 32'd1);
      chk("init_q_stat_updates", 32'(stat_updates), 32'd4);
`endif

      // Back-to-back streaming in RUN
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) push(16'h4000 + 16'(i), 1'(i), 1'b0, 1'b0, 1'b0);
         else        idle(1);
         if (i < 20) chk("stream_ready", 32'(obs_ready), 32'd1);
         if (i >= 1) begin
            chk("stream_write", 32'(obs_write), 32'd1);
            chk("stream_pc", 32'(obs_pc), 32'h4000 + 32'(i - 1));
         end
      end

      // Reset mid-drain: queued entries discarded, sweep restarts
      do_reset();
      for (int k = 0; k < 3; k++) push(16'h6000 + 16'(k), 1'b0, 1'b1, 1'b0, 1'b0);
      idle(4);
      do_reset();
      chk("middrain_index_at_reset", 32'(obs_index), 32'd7);
      idle(1);
      chk("middrain_restart_index", 32'(obs_index), 32'd0);
      wcnt = 0;
      for (int i = 0; i < 25; i++) begin
         idle(1);
         if (obs_write) wcnt++;
      end
      chk("middrain_no_writes", 32'(wcnt), 32'd0);

      // Random traffic against the model (checked every cycle)
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cycle(1'b0, ($urandom_range(0, 9) < 7), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         end
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
